// File: rtl/add_arbiter_seq.sv
// Two-requester round-robin arbiter in front of a W-bit add/subtract unit.
// All arithmetic runs through one 4-bit adder slice, one nibble per cycle, LSB first.
module add_arbiter_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         sub0,
    input  logic         sub1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         done,
    output logic         done_id
);

    localparam int N  = W / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((W % 4) != 0 || W < 4) begin : g_bad_width
            $error("add_arbiter_seq: W must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_lat;
    logic [W-1:0]   b_lat;
    logic [W-1:0]   shadow;
    logic [W-1:0]   shadow_next;
    logic           carry;
    logic [CW-1:0]  nib;
    logic           id_lat;
    logic           last_gnt;
    logic [3:0]     slice_sum;
    logic           slice_cout;
    logic           grant0;
    logic           grant1;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_sub;

    // The single shared 4-bit slice; shadow_next is the shadow with this cycle's nibble merged in.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_lat[4*nib +: 4]} + {1'b0, b_lat[4*nib +: 4]} + {4'b0000, carry};
        shadow_next = shadow;
        shadow_next[4*nib +: 4] = slice_sum;
    end

    // last_gnt remembers who won last; on contention the other requester wins.
    always_comb begin
        grant0  = req0 & (~req1 | last_gnt);
        grant1  = req1 & ~grant0;
        sel_a   = grant1 ? a1 : a0;
        sel_b   = grant1 ? b1 : b0;
        sel_sub = grant1 ? sub1 : sub0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            cout     <= 1'b0;
            result   <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            shadow   <= '0;
            carry    <= 1'b0;
            nib      <= '0;
            id_lat   <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        gnt0     <= grant0;
                        gnt1     <= grant1;
                        id_lat   <= grant1;
                        last_gnt <= grant1;
                        a_lat    <= sel_a;
                        // Subtraction as a + ~b + 1: invert b here, seed the carry with 1.
                        b_lat    <= sel_sub ? ~sel_b : sel_b;
                        carry    <= sel_sub;
                        nib      <= '0;
                        shadow   <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    shadow <= shadow_next;
                    carry  <= slice_cout;
                    nib    <= nib + 1'b1;
                    if (nib == LAST) begin
                        result  <= shadow_next;
                        cout    <= slice_cout;
                        done_id <= id_lat;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter_seq.sv
// Directed bench for add_arbiter_seq (W=8): vector table of single operations,
// then mid-operation reset and two-requester contention sequences.
module tb_add_arbiter_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         sub0, sub1;
    logic         gnt0, gnt1, busy, cout, done, done_id;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    add_arbiter_seq #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .sub0    (sub0),
        .sub1    (sub1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .result  (result),
        .cout    (cout),
        .done    (done),
        .done_id (done_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_result;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[12];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, " gnt0"}, 32'(gnt0), 0);
        check_val({name, " gnt1"}, 32'(gnt1), 0);
        check_val({name, " busy"}, 32'(busy), 0);
        check_val({name, " done"}, 32'(done), 0);
        check_val({name, " done_id"}, 32'(done_id), 0);
        check_val({name, " cout"}, 32'(cout), 0);
        check_val({name, " result"}, 32'(result), 0);
    endtask

    task automatic wait_grant(output logic got);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (gnt0 || gnt1) got = 1'b1;
        end
    endtask

    // One full transaction: request, grant, operands scrambled in flight, then timed done checks.
    task automatic run_op(input vec_t v, input string name);
        logic got;
        @(negedge clk);
        if (v.id == 1'b0) begin
            req0 = 1'b1; a0 = v.a; b0 = v.b; sub0 = v.sub;
        end else begin
            req1 = 1'b1; a1 = v.a; b1 = v.b; sub1 = v.sub;
        end
        wait_grant(got);
        check_val({name, " grant seen"}, 32'(got), 1);
        if (got) begin
            check_val({name, " gnt"}, 32'({gnt1, gnt0}), v.id ? 32'd2 : 32'd1);
            req0 = 1'b0; req1 = 1'b0;
            a0 = ~v.a; b0 = ~v.b; sub0 = ~v.sub;
            a1 = ~v.a; b1 = ~v.b; sub1 = ~v.sub;
            @(posedge clk); #1;
            check_val({name, " gnt pulse end"}, 32'({gnt1, gnt0}), 0);
            check_val({name, " done early"}, 32'(done), 0);
            check_val({name, " busy"}, 32'(busy), 1);
            @(posedge clk); #1;
            check_val({name, " done"}, 32'(done), 1);
            check_val({name, " result"}, 32'(result), 32'(v.exp_result));
            check_val({name, " cout"}, 32'(cout), 32'(v.exp_cout));
            check_val({name, " done_id"}, 32'(done_id), 32'(v.id));
            @(posedge clk); #1;
            check_val({name, " done end"}, 32'(done), 0);
            check_val({name, " busy end"}, 32'(busy), 0);
            check_val({name, " result hold"}, 32'(result), 32'(v.exp_result));
        end
    endtask

    initial begin
        logic got;
        logic exp_id;
        vec_t v;

        vecs[0]  = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0};
        vecs[4]  = '{1'b1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1};
        vecs[5]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[7]  = '{1'b0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        vecs[8]  = '{1'b1, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        vecs[10] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        sub0 = 1'b0; sub1 = 1'b0;

        #12 rst_n = 1'b0;
        #1 check_reset_outputs("initial reset");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during CALC must clear everything at once and suppress the done pulse.
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h33; b0 = 8'h44; sub0 = 1'b0;
        wait_grant(got);
        check_val("midop grant seen", 32'(got), 1);
        req0 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midop reset");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("midop no done c%0d", i), 32'(done), 0);
            check_val($sformatf("midop idle c%0d", i), 32'(busy), 0);
        end
        v = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        run_op(v, "after reset");

        // Both requesters held high: grants alternate starting with 0 after reset.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("contention reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        req0 = 1'b1; a0 = 8'h11; b0 = 8'h22; sub0 = 1'b0;
        req1 = 1'b1; a1 = 8'h50; b1 = 8'h20; sub1 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp_id = r[0];
            wait_grant(got);
            check_val($sformatf("rr%0d grant seen", r), 32'(got), 1);
            if (!got) break;
            check_val($sformatf("rr%0d gnt", r), 32'({gnt1, gnt0}), exp_id ? 32'd2 : 32'd1);
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(posedge clk); #1;
                if (done) got = 1'b1;
            end
            check_val($sformatf("rr%0d done seen", r), 32'(got), 1);
            check_val($sformatf("rr%0d done_id", r), 32'(done_id), 32'(exp_id));
            check_val($sformatf("rr%0d result", r), 32'(result), exp_id ? 32'h30 : 32'h33);
            check_val($sformatf("rr%0d cout", r), 32'(cout), exp_id ? 32'd1 : 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_arbiter_seq.md
ADD_ARBITER_SEQ -- requirements
Module: add_arbiter_seq

Interface
REQ-001 The block SHALL take parameter W, default 8: operand/result width in bits; it SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0/req1  input  1 each  service request from requester 0/1.
REQ-005 The block SHALL have ports a0/b0, a1/b1  input  W each  operands of requester 0/1.
REQ-006 The block SHALL have ports sub0/sub1  input  1 each  operation select: 0 = a+b, 1 = a-b.
REQ-007 The block SHALL have ports gnt0/gnt1  output  1 each  one-cycle grant pulse: operands captured.
REQ-008 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 The block SHALL have port result  output  W  last completed sum/difference.
REQ-010 The block SHALL have port cout  output  1  carry-out of the last operation; for subtract, 1 = no borrow.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse: result/cout/done_id valid and updated.
REQ-012 The block SHALL have port done_id  output  1  requester index of the completed operation.

Function
REQ-013 The block SHALL contain exactly one 4-bit full-adder slice (sum plus carry-out) and SHALL time-share it for all arithmetic.
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; reset state is IDLE.
REQ-015 IDLE: at an edge where req0 or req1 is high, the FSM SHALL grant one requester, latch its a, b and sub, and go to CALC; with no request it SHALL stay in IDLE.
REQ-016 Grant SHALL follow a round-robin rule: if only one requester is asserting, it wins; if both are asserting, the requester not granted last wins; requester 0 wins the first contention after reset.
REQ-017 gnt0/gnt1 SHALL be registered, one-hot-or-zero, and high for exactly the one cycle following the granting edge.
REQ-018 Requests SHALL be sampled only in IDLE; a request withdrawn before being granted is dropped without side effects.
REQ-019 Subtract SHALL be performed as a + ~b + 1: latch the inverted b and set the carry register to sub at the grant edge.
REQ-020 CALC SHALL last W/4 cycles and process nibble i (LSB first) in cycle i. The slice inputs are a[4i+3:4i], the latched b nibble, and the carry register. The nibble sum goes to a shadow register; the carry register takes the slice carry-out.
REQ-021 At the final CALC edge, the FSM SHALL go to DONE and SHALL copy the shadow register to result, the carry to cout, and the granted index to done_id.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; no request is sampled in DONE.
REQ-023 Latency: with a grant edge at t, done SHALL be high during the cycle after edge t+W/4; for W=8 this is 3 cycles after the grant edge.
REQ-024 result, cout and done_id SHALL hold their values between done pulses; inputs changing after the grant SHALL NOT affect the operation in flight.
REQ-025 Width rule: result SHALL be (a ± b) mod 2^W; cout SHALL be bit W of the unsigned sum a + (sub ? ~b+1 : b).

Reset
REQ-026 rst_n low SHALL immediately clear state to IDLE and set gnt0, gnt1, busy, done, done_id, cout and result to 0. It SHALL also clear the shadow/carry registers and set the round-robin pointer so that requester 0 wins next.
REQ-027 Reset during CALC or DONE SHALL discard the operation; no done pulse SHALL follow. Once rst_n is high, operation SHALL resume at the next edge with a request.

Verification
REQ-028 Reset check: assert rst_n=0 mid-cycle -> all outputs 0 at once, without waiting for a clock edge.
REQ-029 Simple add: req0=1, a0=0x0F, b0=0x01, sub0=0 -> gnt0 for 1 cycle; done 3 cycles after grant edge with result=0x10, cout=0, done_id=0.
REQ-030 Carry chain: a0=0xFF, b0=0x01, add -> result=0x00, cout=1. Then a0=0x0F, b0=0xF1 -> result=0x00, cout=1.
REQ-031 Subtract: a1=0x05, b1=0x07, sub1=1 -> result=0xFE, cout=0, done_id=1. Then a1=0x07, b1=0x05 -> result=0x02, cout=1.
REQ-032 Contention: req0 and req1 both held high continuously -> grants alternate 0,1,0,1, starting with 0 after reset; each done_id matches its grant. Check also that a lone requester is granted on consecutive rounds.
REQ-033 Reset mid-operation: rst_n pulsed low during CALC -> no done pulse and outputs 0; the next request afterwards completes with the correct result.
